pixel_feed_buffer: RTL
======================

Name: pixel_feed_buffer

Overview:
- Upstream stage of the get3 pixel-fetch conduit in the Nios/WiFi system.
- Counts coordinates on a raw RGB video stream and decimates it spatially.
- Buffers the kept pixels in a small FIFO.
- Presents one buffered pixel (r, g, b, x, y plus a valid flag) on each rising edge of the software-driven request line (reqclk), so firmware can pull pixels at its own rate.

Parameters:
- H_ACTIVE, 640, active pixels per line; x counter wraps at H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; y counter wraps at V_ACTIVE-1.
- DECIM_LOG2, 2, keep a pixel only when x and y are both multiples of 2^DECIM_LOG2 (0 = keep all).
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- clk_clk  in  1  system clock; all logic is on this single clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- vid_valid  in  1  input pixel strobe, one pixel per cycle when high.
- vid_sof  in  1  qualified by vid_valid; marks the first pixel of a frame.
- vid_r / vid_g / vid_b  in  8 each  input pixel colour.
- capture_arm  in  1  level; capture is enabled when high (driven from frame_controller sw0).
- reqclk  in  1  pull request from the get3 conduit; asynchronous level, synchronized internally.
- r_out / g_out / b_out  out  8 each  presented pixel colour (to get3 r/g/b).
- x_out / y_out  out  11 each  presented pixel coordinates (to get3 x/y).
- sw_out  out  1  presented pixel valid (to get3 sw).
- overflow  out  1  sticky; set when a kept pixel was dropped because the FIFO was full.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values: all data outputs 0, sw_out 0, overflow 0, fifo_level 0. Reset also clears the FIFO, the counters, the synchronizer and the capture state.
- Coordinate counters advance only on vid_valid.
  - vid_sof with vid_valid loads x=0, y=0 for that pixel.
  - Otherwise x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - At y=V_ACTIVE-1 with x=H_ACTIVE-1, both wrap to 0.
  - Counters are 11-bit unsigned.
- Capture state machine:
  - IDLE: leaves to CAPTURE on a pixel with vid_valid & vid_sof & capture_arm. That SOF pixel is itself eligible for capture.
  - CAPTURE: on any vid_sof pixel where capture_arm=0, goes to IDLE and that pixel is not pushed. If capture_arm falls mid-frame, capture continues to the end of the frame; capture never starts or stops mid-frame.
- Push: in CAPTURE, when vid_valid is high and the low DECIM_LOG2 bits of both x and y are 0, write {r,g,b,x,y} (46 bits) into the FIFO.
- Overflow: a push while the FIFO is full drops the pixel and sets overflow. overflow clears on the next capture-start SOF or on reset.
- reqclk handling:
  - Two-flop synchronizer, then a rising-edge detector (req_rise).
  - req_rise is a single cycle, asserted 3 clk_clk cycles after reqclk rises.
- Pop on req_rise:
  - FIFO non-empty: pop the head; outputs take the popped values and sw_out=1 on the next clock edge.
  - FIFO empty: sw_out=0 on the next edge; data outputs hold their last values.
  - Outputs are otherwise stable between req_rise events.
- Simultaneous push and pop:
  - Both proceed; fifo_level is unchanged.
  - When full, the pop frees a slot, so the push succeeds and overflow is not set.
  - When empty, the pushed pixel is not bypassed; sw_out=0, and the pixel is delivered on the next req_rise.
- FIFO: first-word-fall-through head register, so pop-to-output latency is 1 cycle.

Decomposition:
- Shared package pixel_feed_pkg:
  - width constants: COLOR_W=8, COORD_W=11.
  - packed struct pixel_t {r, g, b, x, y}.
  - enum cap_state_t {IDLE, CAPTURE}.
- One sub-module: pix_fifo.
  - Synchronous FIFO of pixel_t, parameterised by FIFO_AW.
  - Ports: push/pop/full/empty/level, same clock and async reset.
- The top level contains the counters, decimation, capture FSM, synchronizer and output registers.

Test Plan:
- Reset during activity:
  - Stimulus: assert reset_reset_n=0 mid-capture with 5 entries queued.
  - Required: all outputs 0, fifo_level 0; after release, no pixels are delivered until the next SOF.
- Decimation:
  - Stimulus: DECIM_LOG2=2, capture_arm=1, one 640x480 frame, then 4 pulls.
  - Required: pulls return (x,y) = (0,0), (4,0), (8,0), (12,0) with matching colours, each with sw_out=1.
- Pull latency:
  - Stimulus: raise reqclk at cycle T with the FIFO non-empty.
  - Required: new outputs and sw_out=1 visible at cycle T+4; a pull on an empty FIFO gives sw_out=0 with data held.
- Overflow:
  - Stimulus: FIFO_AW=4, no pulls, 20 kept pixels.
  - Required: fifo_level=16, overflow=1, and the first pull returns pixel 0.
  - Stimulus: the next armed SOF.
  - Required: overflow=0.
- Arm gating:
  - Stimulus: drop capture_arm at line 100.
  - Required: capture continues through (636,476).
  - Stimulus: the next SOF with arm low.
  - Required: no pushes.
  - Stimulus: re-arm mid-frame.
  - Required: no pushes until the following SOF.
- Push and pop together:
  - Stimulus: FIFO full while req_rise and a kept pixel coincide.
  - Required: level stays 16, overflow stays 0, no pixel is lost.

Source files
------------

// File: rtl/pixel_feed_pkg.sv
// pixel_feed_pkg
//   Shared types and constants for the pixel feed buffer slice.
//   COLOR_W / COORD_W : widths of one colour channel and one coordinate.
//   pixel_t           : packed {r, g, b, x, y} record held in the FIFO (46 bits).
//   cap_state_t       : capture state machine encoding.
//   is_kept()         : decimation test on a coordinate pair.
package pixel_feed_pkg;

  localparam int COLOR_W = 8;
  localparam int COORD_W = 11;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  // A pixel survives decimation when the low decim_log2 bits of both
  // coordinates are zero; decim_log2 = 0 gives an all-zero mask (keep all).
  function automatic logic is_kept(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y,
                                   input int                 decim_log2);
    logic [COORD_W-1:0] mask;
    mask = COORD_W'((1 << decim_log2) - 1);
    return ((x & mask) == '0) && ((y & mask) == '0);
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo
//   Synchronous FIFO of pixel_t with a first-word-fall-through head: the
//   oldest entry is always visible on 'head' while the FIFO is non-empty.
//   Ports:
//     clk, rst_n      : clock and asynchronous active-low reset
//     push, push_data : write request and pixel to store
//     pop             : remove the head entry (ignored when empty)
//     head            : oldest stored pixel (valid only when !empty)
//     full, empty     : occupancy flags
//     level           : number of stored entries (0 .. 2**FIFO_AW)
module pix_fifo
  import pixel_feed_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  pixel_t           push_data,
  input  logic             pop,
  output pixel_t           head,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] level
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(DEPTH);

  pixel_t             mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in,
  // so a push is only refused when full and not popping.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_feed_buffer.sv
// pixel_feed_buffer
//   Counts coordinates on a raw RGB stream, decimates it, buffers kept
//   pixels in pix_fifo and presents one pixel per rising edge of reqclk.
//   Ports:
//     clk_clk, reset_reset_n   : clock, asynchronous active-low reset
//     vid_valid, vid_sof       : pixel strobe and start-of-frame marker
//     vid_r, vid_g, vid_b      : input colour
//     capture_arm              : level enable, sampled only at SOF
//     reqclk                   : asynchronous pull request from firmware
//     r_out, g_out, b_out      : presented colour
//     x_out, y_out             : presented coordinates
//     sw_out                   : presented pixel valid
//     overflow                 : sticky drop flag, cleared at armed SOF
//     fifo_level               : FIFO occupancy
module pixel_feed_buffer
  import pixel_feed_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               vid_valid,
  input  logic               vid_sof,
  input  logic [COLOR_W-1:0] vid_r,
  input  logic [COLOR_W-1:0] vid_g,
  input  logic [COLOR_W-1:0] vid_b,
  input  logic               capture_arm,
  input  logic               reqclk,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               sw_out,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  cap_state_t         state;
  cap_state_t         state_next;
  logic               capturing;
  logic               cap_start;
  logic               push;
  logic               req_meta;
  logic               req_sync;
  logic               req_prev;
  logic               req_rise;
  pixel_t             push_data;
  pixel_t             head;
  logic               fifo_full;
  logic               fifo_empty;

  // x_cnt/y_cnt hold the coordinate the next pixel will take; an SOF pixel
  // overrides them with (0,0) for itself.
  assign pix_x     = vid_sof ? '0 : x_cnt;
  assign pix_y     = vid_sof ? '0 : y_cnt;
  assign push_data = {vid_r, vid_g, vid_b, pix_x, pix_y};

  // Raster counters: advance once per valid pixel, wrapping at the end of
  // each line and at the end of the frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (vid_valid) begin
      if (pix_x == COORD_W'(H_ACTIVE - 1)) begin
        x_cnt <= '0;
        y_cnt <= (pix_y == COORD_W'(V_ACTIVE - 1)) ? '0 : pix_y + 1'b1;
      end else begin
        x_cnt <= pix_x + 1'b1;
        y_cnt <= pix_y;
      end
    end
  end

  // Capture state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture decisions are only taken at SOF pixels, so a frame is always
  // captured whole or not at all; the SOF pixel itself follows capture_arm.
  always_comb begin
    state_next = state;
    capturing  = 1'b0;
    cap_start  = 1'b0;
    push       = 1'b0;
    if (vid_valid) begin
      if (vid_sof) begin
        cap_start  = capture_arm;
        capturing  = capture_arm;
        state_next = capture_arm ? CAPTURE : IDLE;
      end else begin
        capturing = (state == CAPTURE);
      end
      push = capturing && is_kept(pix_x, pix_y, DECIM_LOG2);
    end
  end

  // reqclk synchronizer and registered edge detector; req_rise pulses for
  // one cycle, three cycles after reqclk goes high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_meta <= 1'b0;
      req_sync <= 1'b0;
      req_prev <= 1'b0;
      req_rise <= 1'b0;
    end else begin
      req_meta <= reqclk;
      req_sync <= req_meta;
      req_prev <= req_sync;
      req_rise <= req_sync & ~req_prev;
    end
  end

  pix_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (req_rise),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Presentation registers: each request either loads the FIFO head with
  // sw_out=1, or reports sw_out=0 and keeps the previous data.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      x_out  <= '0;
      y_out  <= '0;
      sw_out <= 1'b0;
    end else if (req_rise) begin
      if (!fifo_empty) begin
        r_out  <= head.r;
        g_out  <= head.g;
        b_out  <= head.b;
        x_out  <= head.x;
        y_out  <= head.y;
        sw_out <= 1'b1;
      end else begin
        sw_out <= 1'b0;
      end
    end
  end

  // Sticky overflow: a drop only happens when full and not popping in the
  // same cycle. A drop on the armed SOF pixel itself wins over the clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !req_rise) begin
      overflow <= 1'b1;
    end else if (cap_start) begin
      overflow <= 1'b0;
    end
  end

endmodule
